// File: rtl/noc_router_rr.sv
// noc_router_rr: five-port XY mesh router with per-input FIFOs, per-output
// round-robin arbitration, credit flow control and registered outputs.

module noc_rr_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           rd_ptr, wr_ptr;
  logic [AW:0]             cnt;
  logic                    full, do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (push && !do_push) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= din;
  end
endmodule

module noc_rr_arb #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr, win;
  logic          found;

  function automatic int wrap(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  // first requester at or after ptr, scanning modulo N
  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (en && !found && req[wrap(int'(ptr) + k)]) begin
        gnt[wrap(int'(ptr) + k)] = 1'b1;
        win   = PW'(wrap(int'(ptr) + k));
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        ptr <= '0;
    else if (found) ptr <= (win == PW'(N-1)) ? '0 : win + 1'b1;
  end
endmodule

module noc_router_rr #(
  parameter int FLIT_W  = 32,
  parameter int COORD_W = 4,
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COORD_W-1:0]    my_x_i,
  input  logic [COORD_W-1:0]    my_y_i,
  input  logic [4:0]            in_valid_i,
  input  logic [4:0][FLIT_W-1:0] in_data_i,
  input  logic [4:0]            credit_i,
  output logic [4:0]            out_valid_o,
  output logic [4:0][FLIT_W-1:0] out_data_o,
  output logic [4:0]            credit_o,
  output logic [4:0]            ovf_o
);
  localparam int NP  = 5;
  localparam int P_N = 0;
  localparam int P_S = 1;
  localparam int P_E = 2;
  localparam int P_W = 3;
  localparam int P_L = 4;
  localparam int CW  = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);

  logic [NP-1:0][FLIT_W-1:0]  head, win_data;
  logic [NP-1:0][COORD_W-1:0] dx, dy;
  logic [NP-1:0]              empty, pop, any_gnt;
  logic [NP-1:0][NP-1:0]      rreq, gnt;   // [output][input]
  logic [NP-1:0][CW-1:0]      crd;

  for (genvar i = 0; i < NP; i++) begin : g_in
    noc_rr_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid_i[i]),
      .pop   (pop[i]),
      .din   (in_data_i[i]),
      .head  (head[i]),
      .empty (empty[i]),
      .ovf   (ovf_o[i])
    );
    assign dx[i] = head[i][FLIT_W-1 -: COORD_W];
    assign dy[i] = head[i][FLIT_W-COORD_W-1 -: COORD_W];
  end

  // dimension-ordered XY: resolve x first, then y, else deliver locally
  always_comb begin
    rreq = '0;
    for (int i = 0; i < NP; i++) begin
      if (!empty[i]) begin
        if (dx[i] > my_x_i)      rreq[P_E][i] = 1'b1;
        else if (dx[i] < my_x_i) rreq[P_W][i] = 1'b1;
        else if (dy[i] > my_y_i) rreq[P_N][i] = 1'b1;
        else if (dy[i] < my_y_i) rreq[P_S][i] = 1'b1;
        else                     rreq[P_L][i] = 1'b1;
      end
    end
  end

  for (genvar o = 0; o < NP; o++) begin : g_out
    noc_rr_arb #(.N(NP)) u_arb (
      .clk (clk),
      .rst (rst),
      .en  (crd[o] != '0),
      .req (rreq[o]),
      .gnt (gnt[o])
    );
    assign any_gnt[o] = |gnt[o];
  end

  // each input has one head, so at most one output can grant it
  always_comb begin
    pop      = '0;
    win_data = '0;
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        if (gnt[o][i]) begin
          pop[i]      = 1'b1;
          win_data[o] = head[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o <= '0;
      out_data_o  <= '0;
      credit_o    <= '0;
    end else begin
      credit_o    <= pop;
      out_valid_o <= any_gnt;
      for (int o = 0; o < NP; o++) begin
        if (any_gnt[o]) out_data_o[o] <= win_data[o];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NP; o++) crd[o] <= CMAX;
    end else begin
      for (int o = 0; o < NP; o++) begin
        if (credit_i[o] && !any_gnt[o]) begin
          if (crd[o] != CMAX) crd[o] <= crd[o] + 1'b1;
        end else if (!credit_i[o] && any_gnt[o]) begin
          crd[o] <= crd[o] - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_noc_router_rr.sv
// Directed bench for noc_router_rr at my=(2,2) with default parameters.
module tb_noc_router_rr;
  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      my_x, my_y;
  logic [4:0]      in_valid, credit_in, out_valid, credit_out, ovf;
  logic [4:0][31:0] in_data, out_data;

  int nchk = 0;
  int nerr = 0;
  int ncred, m;
  logic [31:0] f1 [5];
  int          p1 [5];
  int          srcs [3];

  noc_router_rr dut (
    .clk         (clk),
    .rst         (rst),
    .my_x_i      (my_x),
    .my_y_i      (my_y),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .credit_i    (credit_in),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .credit_o    (credit_out),
    .ovf_o       (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [3:0] x, input logic [3:0] y, input logic [23:0] pl);
    return {x, y, pl};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle;
    in_valid  = '0;
    in_data   = '0;
    credit_in = '0;
  endtask

  task automatic do_reset;
    idle;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
  endtask

  task automatic push_local(input logic [23:0] pl);
    in_valid[4] = 1'b1;
    in_data[4]  = mk(4'd3, 4'd2, pl);
  endtask

  // six flits local->east with no credit return: four leave, the rest stall
  task automatic burst_east(input string tag, input logic [23:0] base);
    for (int j = 0; j < 8; j++) begin
      idle;
      if (j < 6) push_local(base + 24'(j));
      step;
      if (j >= 1 && j <= 4) begin
        chk({tag, "_vld"}, 64'(out_valid), 64'(5'b00100));
        chk({tag, "_dat"}, 64'(out_data[2]), 64'(mk(4'd3, 4'd2, base + 24'(j-1))));
      end else if (j >= 5) begin
        chk({tag, "_stall"}, 64'(out_valid[2]), 64'd0);
      end
    end
  endtask

  // hold credit_i[2] four cycles; the four queued flits at base.. leave in order
  task automatic drain_east(input string tag, input logic [23:0] base);
    for (int j = 0; j < 7; j++) begin
      idle;
      if (j < 4) credit_in[2] = 1'b1;
      step;
      if (j >= 1 && j <= 4) begin
        chk({tag, "_vld"}, 64'(out_valid), 64'(5'b00100));
        chk({tag, "_dat"}, 64'(out_data[2]), 64'(mk(4'd3, 4'd2, base + 24'(j-1))));
      end else if (j >= 5) begin
        chk({tag, "_end"}, 64'(out_valid[2]), 64'd0);
      end
    end
  endtask

  initial begin
    my_x = 4'd2;
    my_y = 4'd2;
    rst  = 1'b1;
    do_reset;
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_dat", 64'(out_data), 64'd0);
    chk("rst_cro", 64'(credit_out), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);

    // routing from the local input
    f1 = '{mk(4'd3, 4'd2, 24'hA10001), mk(4'd1, 4'd2, 24'hB20002), mk(4'd2, 4'd3, 24'hC30003),
           mk(4'd2, 4'd1, 24'hD40004), mk(4'd2, 4'd2, 24'hE50005)};
    p1 = '{2, 3, 0, 1, 4};
    ncred = 0;
    for (int k = 0; k < 7; k++) begin
      idle;
      if (k < 5) begin
        in_valid[4] = 1'b1;
        in_data[4]  = f1[k];
      end
      step;
      ncred += int'(credit_out[4]);
      if (k >= 1 && k <= 5) begin
        m = k - 1;
        chk("rt_vld", 64'(out_valid), 64'(5'b00001 << p1[m]));
        chk("rt_dat", 64'(out_data[p1[m]]), 64'(f1[m]));
        chk("rt_cro", 64'(credit_out), 64'(5'b10000));
      end
    end
    chk("rt_ncred", 64'(ncred), 64'd5);

    // round-robin contention on east, downstream returning credit every cycle
    do_reset;
    srcs = '{0, 1, 3};
    for (int j = 0; j < 11; j++) begin
      idle;
      credit_in[2] = 1'b1;
      if (j < 3) begin
        for (int s = 0; s < 3; s++) begin
          in_valid[srcs[s]] = 1'b1;
          in_data[srcs[s]]  = mk(4'd3, 4'd2, 24'(srcs[s] * 16 + j));
        end
      end
      step;
      if (j >= 1 && j <= 9) begin
        m = j - 1;
        chk("rr_vld", 64'(out_valid), 64'(5'b00100));
        chk("rr_dat", 64'(out_data[2]), 64'(mk(4'd3, 4'd2, 24'(srcs[m % 3] * 16 + m / 3))));
        chk("rr_cro", 64'(credit_out), 64'(5'b00001 << srcs[m % 3]));
      end else if (j == 10) begin
        chk("rr_end", 64'(out_valid[2]), 64'd0);
      end
    end
    chk("rr_ovf", 64'(ovf), 64'd0);

    // credit stall, then single-credit releases
    do_reset;
    burst_east("st", 24'h300);
    idle; step;
    for (int r = 0; r < 2; r++) begin
      idle;
      credit_in[2] = 1'b1;
      step;
      idle;
      chk("st_wait", 64'(out_valid[2]), 64'd0);
      step;
      chk("st_rel_vld", 64'(out_valid[2]), 64'd1);
      chk("st_rel_dat", 64'(out_data[2]), 64'(mk(4'd3, 4'd2, 24'h304 + 24'(r))));
      step;
      chk("st_rel_end", 64'(out_valid[2]), 64'd0);
    end

    // overflow with east credits exhausted
    for (int j = 0; j < 5; j++) begin
      idle;
      push_local(24'h400 + 24'(j));
      step;
      chk("ov_flag", 64'(ovf), (j == 4) ? 64'(5'b10000) : 64'd0);
    end
    drain_east("ov_drain", 24'h400);
    chk("ov_sticky", 64'(ovf), 64'(5'b10000));

    // credit_i coincident with a grant leaves the count at CREDITS
    do_reset;
    idle; push_local(24'h500); step;
    idle; credit_in[2] = 1'b1; step;
    chk("sim_vld", 64'(out_valid), 64'(5'b00100));
    chk("sim_dat", 64'(out_data[2]), 64'(mk(4'd3, 4'd2, 24'h500)));
    idle; step;
    burst_east("sim", 24'h510);
    // fill to four entries, then push in the cycle the head pops
    idle; push_local(24'h516); step;
    idle; push_local(24'h517); step;
    chk("full_ovf", 64'(ovf), 64'd0);
    idle; credit_in[2] = 1'b1; step;
    idle; push_local(24'h518); step;
    chk("pp_vld", 64'(out_valid), 64'(5'b00100));
    chk("pp_dat", 64'(out_data[2]), 64'(mk(4'd3, 4'd2, 24'h514)));
    chk("pp_ovf", 64'(ovf), 64'd0);
    drain_east("pp_drain", 24'h515);
    chk("pp_ovf_end", 64'(ovf), 64'd0);

    // reset with three flits buffered
    do_reset;
    idle;
    for (int s = 0; s < 3; s++) begin
      in_valid[srcs[s]] = 1'b1;
      in_data[srcs[s]]  = mk(4'd3, 4'd2, 24'h600 + 24'(s));
    end
    step;
    idle;
    rst = 1'b1;
    step;
    chk("mr_vld", 64'(out_valid), 64'd0);
    chk("mr_cro", 64'(credit_out), 64'd0);
    chk("mr_dat", 64'(out_data), 64'd0);
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      idle;
      step;
      chk("mr_quiet_vld", 64'(out_valid), 64'd0);
      chk("mr_quiet_cro", 64'(credit_out), 64'd0);
    end
    burst_east("mr", 24'h700);

    $display("[TB] %0d tests run, %0d failed", nchk, nerr);
    $finish;
  end
endmodule
